sha_msg_sched: RTL and testbench

SHA_MSG_SCHED -- requirements
Module: sha_msg_sched

---
 rtl/sha_pkg.sv | 47 ++++
 rtl/sha_sched_next.sv | 42 ++++
 rtl/sha_msg_sched.sv | 150 +++++++++++++++
 tb/tb_sha_msg_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// ============================================================================
//  Module   : sha_pkg
//  Brief    : Shared types, round constants and bit functions for the SHA-1 /
//             SHA-256 message scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha_pkg;

   typedef enum logic [0:0] {
      MODE_SHA1   = 1'b0,
      MODE_SHA256 = 1'b1
   } sha_mode_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sched_state_e;

   localparam int SHA1_ROUNDS   = 80;
   localparam int SHA256_ROUNDS = 64;
   localparam int WIN_WORDS     = 16;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] shr(input logic [31:0] x, input int n);
      return x >> n;
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
   endfunction

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sha_sched_next.sv
// ============================================================================
//  Module   : sha_sched_next
//  Brief    : Combinational next-word generator for the 16-word schedule
//             window. SHA-256 branch present only with SHA_MSG_SCHED_SHA256_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_sched_next
   import sha_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [WIN_WORDS-1:0][N-1:0] win,
   input  sha_mode_e                   mode_q,
   output logic [N-1:0]                next_word
);

   logic [N-1:0] w_sha1;

   assign w_sha1 = rotl1(win[13] ^ win[8] ^ win[2] ^ win[0]);

`ifdef SHA_MSG_SCHED_SHA256_EN
   logic [N-1:0] w_sha256;
   logic         w_unused;

   assign w_sha256  = s1(win[14]) + win[9] + s0(win[1]) + win[0];
   assign next_word = (mode_q == MODE_SHA256) ? w_sha256 : w_sha1;
   // Window slots that neither recurrence taps.
   assign w_unused  = ^{win[15], win[12], win[11], win[10], win[7],
                        win[6], win[5], win[4], win[3]};
`else
   logic w_unused;

   assign next_word = w_sha1;
   assign w_unused  = ^{mode_q, win[15], win[14], win[12], win[11], win[10],
                        win[9], win[7], win[6], win[5], win[4], win[3], win[1]};
`endif

endmodule

`default_nettype wire

// File: rtl/sha_msg_sched.sv
// ============================================================================
//  Module   : sha_msg_sched
//  Brief    : SHA-1 / SHA-256 message schedule generator with valid/ready
//             streaming of Wt. Macro SHA_MSG_SCHED_SHA256_EN enables SHA-256.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_msg_sched
   import sha_pkg::*;
#(
   parameter int N     = 32,
   parameter int RND_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              mode,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [16*N-1:0]   din,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [N-1:0]      w,
   output logic [RND_W-1:0]  w_t,
   output logic              w_last
);

   if (N != 32) begin : g_bad_n
      $error("sha_msg_sched: only N = 32 is supported");
   end
   if (RND_W < 7) begin : g_bad_rnd_w
      $error("sha_msg_sched: RND_W must be at least 7");
   end

   localparam logic [RND_W-1:0] c_last_sha1 = RND_W'(SHA1_ROUNDS - 1);

   sched_state_e                r_state;
   sched_state_e                w_state_nxt;
   logic [RND_W-1:0]            r_t;
   logic [WIN_WORDS-1:0][N-1:0] r_win;
   sha_mode_e                   w_mode_q;
   logic [RND_W-1:0]            w_last_idx;
   logic [N-1:0]                w_next_word;
   logic                        w_accept;
   logic                        w_fire;
   logic                        w_at_last;

`ifdef SHA_MSG_SCHED_SHA256_EN
   localparam logic [RND_W-1:0] c_last_sha256 = RND_W'(SHA256_ROUNDS - 1);

   sha_mode_e r_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_SHA1;
      end else if (clr) begin
         r_mode <= r_mode;
      end else if (w_accept) begin
         r_mode <= sha_mode_e'(mode);
      end
   end

   assign w_mode_q   = r_mode;
   assign w_last_idx = (r_mode == MODE_SHA256) ? c_last_sha256 : c_last_sha1;
`else
   logic w_unused_mode;

   assign w_mode_q      = MODE_SHA1;
   assign w_last_idx    = c_last_sha1;
   assign w_unused_mode = mode;
`endif

   assign w_at_last = (r_t == w_last_idx);
   // clr outranks both handshakes.
   assign w_accept  = (r_state == ST_IDLE) && din_valid && !clr;
   assign w_fire    = (r_state == ST_RUN) && w_ready && !clr;

   sha_sched_next #(
      .N         (N)
   ) u_next (
      .win       (r_win),
      .mode_q    (w_mode_q),
      .next_word (w_next_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (din_valid)           w_state_nxt = ST_RUN;
            ST_RUN:  if (w_ready && w_at_last) w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      din_ready = 1'b0;
      w_valid   = 1'b0;
      w         = '0;
      w_t       = '0;
      w_last    = 1'b0;
      case (r_state)
         ST_IDLE: din_ready = 1'b1;
         ST_RUN: begin
            w_valid = 1'b1;
            w       = r_win[0];
            w_t     = r_t;
            w_last  = w_at_last;
         end
         default: din_ready = 1'b1;
      endcase
   end

   // Window index 0 holds Wt; W0 arrives in the top word of din.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_t   <= '0;
         r_win <= '0;
      end else if (clr) begin
         r_t   <= '0;
         r_win <= '0;
      end else if (w_accept) begin
         r_t <= '0;
         for (int i = 0; i < WIN_WORDS; i++) begin
            r_win[i] <= din[N*(WIN_WORDS-1-i) +: N];
         end
      end else if (w_fire) begin
         r_t <= w_at_last ? '0 : r_t + 1'b1;
         for (int i = 0; i < WIN_WORDS - 1; i++) begin
            r_win[i] <= r_win[i+1];
         end
         r_win[WIN_WORDS-1] <= w_next_word;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sha_msg_sched.sv
// ============================================================================
//  Module   : tb_sha_msg_sched
//  Brief    : Self-checking bench for sha_msg_sched against a direct Wt
//             recurrence model. Honours SHA_MSG_SCHED_SHA256_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha_msg_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         mode;
   logic         din_valid;
   logic         din_ready;
   logic [511:0] din;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w;
   logic [6:0]   w_t;
   logic         w_last;

   int           checks   = 0;
   int           failures = 0;
   logic [31:0]  exp_w [80];
   logic [31:0]  obs_w [80];
   int           n_exp;

   sha_msg_sched #(
      .N         (32),
      .RND_W     (7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .mode      (mode),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .din       (din),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w         (w),
      .w_t       (w_t),
      .w_last    (w_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference: textbook Wt recurrences over the whole 80-entry schedule.
   task automatic build_model(input logic [511:0] blk, input logic m);
      logic eff;
`ifdef SHA_MSG_SCHED_SHA256_EN
      eff = m;
`else
      eff = 1'b0;
`endif
      for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 80; t++) begin
         if (eff) begin
            exp_w[t] = (m_rotr(exp_w[t-2], 17) ^ m_rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (m_rotr(exp_w[t-15], 7) ^ m_rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
         end else begin
            exp_w[t] = m_rotr(exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16], 31);
         end
      end
      n_exp = eff ? 64 : 80;
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // All tasks start and end on a falling edge.
   task automatic send_block(input logic [511:0] blk, input logic m);
      int k = 0;
      while (din_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (din_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_ready: din_ready=%b required 1", din_ready);
      end
      din       = blk;
      mode      = m;
      din_valid = 1'b1;
      build_model(blk, m);
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      din       = rand_block();
      checks++;
      if (w_valid !== 1'b1 || din_ready !== 1'b0 || w_t !== 7'd0) begin
         failures++;
         $display("FAIL load_latency: w_valid=%b din_ready=%b w_t=%0d required 1 0 0",
                  w_valid, din_ready, w_t);
      end
   endtask

   task automatic consume(input int bp_pct, input int stop_at, output int nwords);
      int   idx    = 0;
      int   budget = 0;
      logic hs;
      nwords = 0;
      forever begin
         if (budget > 1000) begin
            checks++;
            failures++;
            $display("FAIL consume_timeout: idx=%0d required completion", idx);
            w_ready = 1'b0;
            return;
         end
         checks++;
         if (w_valid !== 1'b1 || w !== exp_w[idx] || w_t !== 7'(idx)
             || w_last !== 1'(idx == n_exp - 1)) begin
            failures++;
            $display("FAIL word t=%0d: w_valid=%b w=%h w_t=%0d w_last=%b required 1 %h %0d %b",
                     idx, w_valid, w, w_t, w_last, exp_w[idx], idx, (idx == n_exp - 1));
            w_ready = 1'b0;
            return;
         end
         obs_w[idx] = w;
         if (idx == stop_at) begin
            w_ready = 1'b0;
            nwords  = idx;
            return;
         end
         w_ready = ($urandom_range(99) >= bp_pct);
         mode    = 1'($urandom_range(1));
         hs      = w_ready;
         @(posedge clk);
         @(negedge clk);
         budget++;
         if (hs) begin
            nwords = idx + 1;
            if (idx == n_exp - 1) begin
               w_ready = 1'b0;
               checks++;
               if (w_valid !== 1'b0 || din_ready !== 1'b1) begin
                  failures++;
                  $display("FAIL end_bubble: w_valid=%b din_ready=%b required 0 1",
                           w_valid, din_ready);
               end
               return;
            end
            idx++;
         end
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (w_valid !== 1'b0 || din_ready !== 1'b1 || w !== 32'h0 || w_t !== 7'd0 || w_last !== 1'b0) begin
         failures++;
         $display("FAIL %s: w_valid=%b din_ready=%b w=%h w_t=%0d w_last=%b required 0 1 0 0 0",
                  name, w_valid, din_ready, w, w_t, w_last);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; mode = 1'b0; din_valid = 1'b0; w_ready = 1'b0; din = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_values");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_abc_sha1();
      logic [511:0] blk = {32'h61626380, 448'h0, 32'h00000018};
      int n;
      send_block(blk, 1'b0);
      consume(0, -1, n);
      checks++;
      if (n !== 80 || obs_w[16] !== 32'hC2C4C700 || obs_w[17] !== 32'h0 || obs_w[18] !== 32'h30) begin
         failures++;
         $display("FAIL abc_sha1: words=%0d W16=%h W17=%h W18=%h required 80 c2c4c700 0 30",
                  n, obs_w[16], obs_w[17], obs_w[18]);
      end
   endtask

   task automatic test_abc_sha256();
      logic [511:0] blk = {32'h61626380, 448'h0, 32'h00000018};
      int n;
      send_block(blk, 1'b1);
      consume(0, -1, n);
      checks++;
`ifdef SHA_MSG_SCHED_SHA256_EN
      if (n !== 64 || obs_w[16] !== 32'h61626380 || obs_w[17] !== 32'h000F0000) begin
         failures++;
         $display("FAIL abc_sha256: words=%0d W16=%h W17=%h required 64 61626380 000f0000",
                  n, obs_w[16], obs_w[17]);
      end
`else
      if (n !== 80 || obs_w[16] !== 32'hC2C4C700 || obs_w[18] !== 32'h30) begin
         failures++;
         $display("FAIL abc_mode_ignored: words=%0d W16=%h W18=%h required 80 c2c4c700 30",
                  n, obs_w[16], obs_w[18]);
      end
`endif
   endtask

   task automatic test_backpressure();
      int n;
      send_block({32'h61626380, 448'h0, 32'h00000018}, 1'b0);
      consume(50, -1, n);
      checks++;
      if (n !== 80 || obs_w[16] !== 32'hC2C4C700) begin
         failures++;
         $display("FAIL bp_abc: words=%0d W16=%h required 80 c2c4c700", n, obs_w[16]);
      end
      for (int i = 0; i < 4; i++) begin
         send_block(rand_block(), 1'($urandom_range(1)));
         consume(50, -1, n);
         checks++;
         if (n !== n_exp) begin
            failures++;
            $display("FAIL bp_random_count: words=%0d required %0d", n, n_exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 3; i++) begin
         send_block(rand_block(), 1'($urandom_range(1)));
         consume(0, -1, n);
         checks++;
         if (n !== n_exp) begin
            failures++;
            $display("FAIL b2b_count: words=%0d required %0d", n, n_exp);
         end
      end
   endtask

   task automatic test_clr();
      int n;
      send_block(rand_block(), 1'($urandom_range(1)));
      consume(30, 20, n);
      clr     = 1'b1;
      w_ready = 1'($urandom_range(1));
      @(posedge clk);
      @(negedge clk);
      clr     = 1'b0;
      w_ready = 1'b0;
      check_idle_outputs("clr_abort");
      send_block(rand_block(), 1'($urandom_range(1)));
      consume(0, -1, n);
      checks++;
      if (n !== n_exp) begin
         failures++;
         $display("FAIL clr_restart_count: words=%0d required %0d", n, n_exp);
      end
   endtask

   task automatic test_clr_idle();
      clr       = 1'b1;
      din_valid = 1'b1;
      din       = rand_block();
      @(posedge clk);
      @(negedge clk);
      clr       = 1'b0;
      din_valid = 1'b0;
      checks++;
      if (w_valid !== 1'b0) begin
         failures++;
         $display("FAIL clr_idle_accept: w_valid=%b required 0", w_valid);
      end
      @(negedge clk);
      check_idle_outputs("clr_idle_after");
   endtask

   task automatic test_reset_mid();
      int n;
      int stray = 0;
      send_block(rand_block(), 1'($urandom_range(1)));
      consume(0, 40, n);
      w_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (w_valid !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL reset_no_partial: stray_valid_cycles=%0d required 0", stray);
      end
      w_ready = 1'b0;
      send_block({32'h61626380, 448'h0, 32'h00000018}, 1'b0);
      consume(0, -1, n);
      checks++;
      if (n !== 80) begin
         failures++;
         $display("FAIL reset_recover_count: words=%0d required 80", n);
      end
   endtask

   initial begin
      test_reset();
      test_abc_sha1();
      test_abc_sha256();
      test_backpressure();
      test_back_to_back();
      test_clr();
      test_clr_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
